demux_stream: RTL

- 1-to-2 stream demultiplexer; the inverse of the team's 2:1 mux.
- Takes one valid/ready input stream and steers each packet to output A or output B.
- sel_a polarity matches the mux: sel_a=1 selects A, sel_a=0 selects B.
- One registered slot per output, full throughput. Sits between a shared producer and two consumers.

---
 rtl/demux_stream.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/demux_stream.sv
// -----------------------------------------------------------------------------
// demux_stream
//
// 1-to-2 valid/ready stream demultiplexer. Each packet arriving on the input
// stream is steered as a whole to output A or output B. The route is taken
// from sel_a on the first beat of a packet (1 = A, 0 = B) and is locked until
// the beat carrying in_last has been accepted. Each output has a single
// registered slot, so either output sustains one beat per cycle.
//
// Parameters:
//   WIDTH  data width of the input and both outputs
//   CNT_W  width of the per-output beat counters (DEMUX_CNT_EN builds only)
//
// Ports:
//   clk, rst                        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last/sel_a   input stream and route select
//   out_a_valid/out_a_ready/out_a_data/out_a_last  output slot A
//   out_b_valid/out_b_ready/out_b_data/out_b_last  output slot B
//   cnt_a, cnt_b                    beats loaded into each slot (DEMUX_CNT_EN only)
//   busy                            a multi-beat packet is in progress
//
// Build option:
//   DEMUX_CNT_EN  when defined, adds the wrapping beat counters cnt_a / cnt_b.
// -----------------------------------------------------------------------------
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             sel_a,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_last,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_last,
`ifdef DEMUX_CNT_EN
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ROUTE_A,
    ROUTE_B
  } state_t;

  state_t             state_q, state_d;

  logic               a_valid_q, a_valid_d;
  logic [WIDTH-1:0]   a_data_q,  a_data_d;
  logic               a_last_q,  a_last_d;

  logic               b_valid_q, b_valid_d;
  logic [WIDTH-1:0]   b_data_q,  b_data_d;
  logic               b_last_q,  b_last_d;

  logic               target_a;
  logic               slot_a_free;
  logic               slot_b_free;
  logic               accept;
  logic               load_a;
  logic               load_b;

  // Route: sel_a only matters between packets; inside a packet the state
  // register holds the locked destination.
  assign target_a    = (state_q == IDLE) ? sel_a : (state_q == ROUTE_A);

  // A slot can take a new beat if it is empty or is being drained this cycle.
  assign slot_a_free = !a_valid_q || out_a_ready;
  assign slot_b_free = !b_valid_q || out_b_ready;

  // Readiness looks only at the target slot, so a stalled consumer on the
  // other output never blocks the current packet.
  assign in_ready    = target_a ? slot_a_free : slot_b_free;
  assign accept      = in_valid && in_ready;
  assign load_a      = accept &&  target_a;
  assign load_b      = accept && !target_a;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // that is what keeps this block from inferring latches.
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    a_last_d  = a_last_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_last_d  = b_last_q;
    state_d   = state_q;

    // Load wins over drain: a simultaneous drain+load keeps valid high.
    if (load_a) begin
      a_valid_d = 1'b1;
      a_data_d  = in_data;
      a_last_d  = in_last;
    end else if (out_a_ready) begin
      a_valid_d = 1'b0;
    end

    if (load_b) begin
      b_valid_d = 1'b1;
      b_data_d  = in_data;
      b_last_d  = in_last;
    end else if (out_b_ready) begin
      b_valid_d = 1'b0;
    end

    if (accept) begin
      if (in_last) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        state_d = sel_a ? ROUTE_A : ROUTE_B;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the slot data registers are reset too, because the outputs
      // must read as zero after reset, not just be marked invalid.
      state_q   <= IDLE;
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_last_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      a_last_q  <= a_last_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_last_q  <= b_last_d;
    end
  end

  assign out_a_valid = a_valid_q;
  assign out_a_data  = a_data_q;
  assign out_a_last  = a_last_q;
  assign out_b_valid = b_valid_q;
  assign out_b_data  = b_data_q;
  assign out_b_last  = b_last_q;
  assign busy        = (state_q != IDLE);

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  // Counted at load time; the natural CNT_W-bit overflow gives the wrap.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (load_a) cnt_a_d = cnt_a_q + CNT_W'(1);
    if (load_b) cnt_b_d = cnt_b_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`else
  // Keeps CNT_W referenced in builds without the counters.
  logic [CNT_W-1:0] cnt_unused;
  assign cnt_unused = '0;
`endif

endmodule
